sound_req_queue: RTL and testbench

SOUND_REQ_QUEUE -- requirements
Module: sound_req_queue

---
 rtl/sound_req_queue.sv | 136 +++++++++++++
 tb/tb_sound_req_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_req_queue.sv
// Game-event sound request queue: buffers event codes in a small FIFO and paces
// requests to the sound player. Define SOUND_PRIORITY_EN to let code 7 pre-empt the queue.
module sound_req_queue #(
  parameter int DEPTH         = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   evt_valid,
  input  logic [2:0]             evt_code,
  input  logic                   player_busy,
  output logic                   play_sound,
  output logic [2:0]             sound_code,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP} state_t;

  state_t          state;
  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   tmr;
  logic            prio_pend;
  logic            push_req;
  logic            prio;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;

  assign push_req = evt_valid && (evt_code != 3'd0);
  assign full     = (queue_count == FULL_CNT);
  assign empty    = (queue_count == '0);

`ifdef SOUND_PRIORITY_EN
  assign prio = evt_valid && (evt_code == 3'd7);
`else
  assign prio = 1'b0;
`endif

  // A priority event flushes the queue, so nothing is popped or pushed that cycle.
  assign pop  = (state == ISSUE) && !prio_pend && !empty && !prio;
  assign push = push_req && !prio && (!full || pop);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      overflow    <= 1'b0;
    end else if (prio) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      queue_count <= queue_count + 1'b1;
      else if (pop && !push) queue_count <= queue_count - 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= evt_code;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      tmr        <= '0;
      play_sound <= 1'b0;
      sound_code <= 3'd0;
      prio_pend  <= 1'b0;
    end else begin
      play_sound <= 1'b0;
      if (prio) begin
        state     <= ISSUE;
        prio_pend <= 1'b1;
        tmr       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!empty && !player_busy) state <= ISSUE;
          end
          ISSUE: begin
            if (prio_pend || !empty) begin
              play_sound <= 1'b1;
              sound_code <= prio_pend ? 3'd7 : mem[rd_ptr];
              state      <= WAIT_START;
            end else begin
              state <= IDLE;
            end
            prio_pend <= 1'b0;
            tmr       <= '0;
          end
          WAIT_START: begin
            if (player_busy) begin
              state <= WAIT_DONE;
            end else if (tmr == START_LAST) begin
              state <= GAP;
              tmr   <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          WAIT_DONE: begin
            if (!player_busy) begin
              state <= GAP;
              tmr   <= '0;
            end
          end
          GAP: begin
            if (tmr == GAP_LAST) state <= IDLE;
            else                 tmr   <= tmr + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_req_queue.sv
// Self-checking bench for sound_req_queue: vector table, directed timing sequences,
// and random traffic against a transaction-level timing model of the queue and pacing rules.
module tb_sound_req_queue;

  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TOUT  = 8;
`ifdef SOUND_PRIORITY_EN
  localparam int MAXC  = 6;
`else
  localparam int MAXC  = 7;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       evt_valid = 1'b0;
  logic [2:0] evt_code = 3'd0;
  logic       player_busy = 1'b0;
  logic       play_sound;
  logic [2:0] sound_code;
  logic [2:0] queue_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pcyc[$];
  int pcode[$];

  typedef struct packed {
    logic       v;
    logic [2:0] c;
    logic       b;
    logic       ep;
    logic [2:0] ec;
    logic [2:0] en;
    logic       eo;
  } vec_t;

  sound_req_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .START_TIMEOUT(TOUT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .player_busy (player_busy),
    .play_sound  (play_sound),
    .sound_code  (sound_code),
    .queue_count (queue_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    evt_valid   = 1'b0;
    evt_code    = 3'd0;
    player_busy = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic push_evt(input logic [2:0] code);
    evt_valid = 1'b1;
    evt_code  = code;
    step();
    evt_valid = 1'b0;
    evt_code  = 3'd0;
  endtask

  // Runs a bounded window, recording every play_sound pulse; the player optionally
  // raises busy pd cycles after a pulse and keeps it high for pl cycles.
  task automatic collect(input int cycles, input bit resp, input int pd, input int pl);
    int bs;
    int be;
    bs = 0;
    be = 0;
    pcyc.delete();
    pcode.delete();
    for (int k = 0; k < cycles; k++) begin
      if (play_sound === 1'b1) begin
        pcyc.push_back(cyc);
        pcode.push_back(int'(sound_code));
        if (resp) begin
          bs = cyc + pd;
          be = cyc + pd + pl;
        end
      end
      player_busy = (cyc >= bs) && (cyc < be);
      step();
    end
  endtask

  task automatic check_pulse(input string tag, input int i, input int base, input int off, input int code);
    check({tag, "_cyc"},  (i < pcyc.size())  ? pcyc[i] - base : -1, off);
    check({tag, "_code"}, (i < pcode.size()) ? pcode[i]       : -1, code);
  endtask

  initial begin
    vec_t vt[7];
    int   e;
    int   n0;
    int   mq[$];
    int   issue_edge;
    int   idle_from;
    int   bs;
    int   be;
    int   pd;
    int   pl;
    int   n;
    int   g;
    int   sz;
    bit   pop;
    int   ecode;
    bit   eplay;
    bit   eovf;

    // Fill to DEPTH while the player is busy, overflow on the fifth, then a code-0 strobe.
    vt[0] = '{1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 3'd1, 1'b0};
    vt[1] = '{1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0};
    vt[2] = '{1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 3'd3, 1'b0};
    vt[3] = '{1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 3'd4, 1'b0};
    vt[4] = '{1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 3'd4, 1'b1};
    vt[5] = '{1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 3'd4, 1'b1};
    vt[6] = '{1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd4, 1'b1};

    @(negedge clk);
    do_reset();
    check("rst_play",  play_sound,  0);
    check("rst_code",  sound_code,  0);
    check("rst_count", queue_count, 0);
    check("rst_ovf",   overflow,    0);

    player_busy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      evt_valid   = vt[i].v;
      evt_code    = vt[i].c;
      player_busy = vt[i].b;
      step();
      check("vec_play",  play_sound,  vt[i].ep);
      check("vec_code",  sound_code,  vt[i].ec);
      check("vec_count", queue_count, vt[i].en);
      check("vec_ovf",   overflow,    vt[i].eo);
    end

    // Player never answers: each sound times out, gaps, and the next issues 26 cycles later.
    evt_valid = 1'b0;
    n0 = cyc;
    collect(90, 1'b0, 0, 0);
    check("fifo_npulse", pcyc.size(), 4);
    check_pulse("fifo0", 0, n0, 2,  1);
    check_pulse("fifo1", 1, n0, 28, 2);
    check_pulse("fifo2", 2, n0, 54, 4);
    check_pulse("fifo3", 3, n0, 80, 5);
    check("fifo_count_end", queue_count, 0);
    check("fifo_ovf_sticky", overflow, 1);

    // Player rises one cycle after the pulse and stays busy 24 cycles.
    do_reset();
    evt_valid = 1'b1;
    evt_code  = 3'd3;
    step();
    e = cyc;
    evt_code = 3'd5;
    step();
    evt_valid = 1'b0;
    evt_code  = 3'd0;
    check("busy_count", queue_count, 2);
    collect(70, 1'b1, 1, 24);
    check("busy_npulse", pcyc.size(), 2);
    check_pulse("busy0", 0, e, 2,  3);
    check_pulse("busy1", 1, e, 46, 5);

`ifdef SOUND_PRIORITY_EN
    do_reset();
    player_busy = 1'b1;
    push_evt(3'd3);
    push_evt(3'd4);
    check("prio_count_pre", queue_count, 2);
    push_evt(3'd7);
    check("prio_count", queue_count, 0);
    step();
    check("prio_play", play_sound, 1);
    check("prio_code", sound_code, 7);
`else
    do_reset();
    player_busy = 1'b1;
    push_evt(3'd3);
    push_evt(3'd4);
    push_evt(3'd7);
    check("seven_count", queue_count, 3);
    player_busy = 1'b0;
    n0 = cyc;
    collect(70, 1'b0, 0, 0);
    check("seven_npulse", pcyc.size(), 3);
    check_pulse("seven0", 0, n0, 2,  3);
    check_pulse("seven1", 1, n0, 28, 4);
    check_pulse("seven2", 2, n0, 54, 7);
`endif

    // Reset while the player is busy with two events still queued.
    do_reset();
    push_evt(3'd1);
    step();
    step();
    check("rstmid_play", play_sound, 1);
    check("rstmid_code", sound_code, 1);
    player_busy = 1'b1;
    push_evt(3'd2);
    push_evt(3'd4);
    check("rstmid_count", queue_count, 2);
    rstn = 1'b0;
    step();
    check("rstmid_r_play",  play_sound,  0);
    check("rstmid_r_code",  sound_code,  0);
    check("rstmid_r_count", queue_count, 0);
    check("rstmid_r_ovf",   overflow,    0);
    rstn        = 1'b1;
    player_busy = 1'b0;
    collect(60, 1'b0, 0, 0);
    check("rstmid_no_issue", pcyc.size(), 0);

    // Random traffic against a timing model: issue edge, gap end and queue contents
    // are derived from the pacing rules with plain arithmetic.
    do_reset();
    n          = cyc;
    idle_from  = n + 1;
    issue_edge = -1;
    mq.delete();
    ecode = 0;
    eplay = 1'b0;
    eovf  = 1'b0;
    bs = 0;
    be = 0;
    pd = 0;
    pl = 0;
    for (int k = 0; k < 800; k++) begin
      check("rnd_play",  play_sound,  eplay);
      check("rnd_code",  sound_code,  ecode);
      check("rnd_count", queue_count, mq.size());
      check("rnd_ovf",   overflow,    eovf);
      if (play_sound === 1'b1) begin
        bs = cyc + pd;
        be = cyc + pd + pl;
      end
      player_busy = (cyc >= bs) && (cyc < be);
      evt_valid   = ($urandom_range(0, 5) == 0);
      evt_code    = 3'($urandom_range(0, MAXC));
      step();
      n   = cyc;
      sz  = mq.size();
      pop = (n == issue_edge);
      eplay = pop;
      if (pop) begin
        ecode = mq.pop_front();
        issue_edge = -1;
        if ($urandom_range(0, 2) == 0) begin
          pd = 0;
          pl = 0;
          g  = n + TOUT;
        end else begin
          pd = $urandom_range(0, 2);
          pl = $urandom_range(1, 4);
          g  = n + pd + pl + 1;
        end
        idle_from = g + GAP + 1;
      end else if (issue_edge < 0 && n >= idle_from && sz != 0 && !player_busy) begin
        issue_edge = n + 1;
      end
      if (evt_valid && evt_code != 3'd0) begin
        if (sz == DEPTH && !pop) eovf = 1'b1;
        else                     mq.push_back(int'(evt_code));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
